// File: rtl/blur_pkg.sv
// blur_pkg: shared state encoding and 5x5 kernel geometry for the blur pipeline.
package blur_pkg;
  typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;
  localparam int KSIZE = 5;
  localparam int NBUF = 4;
  localparam int HALF = 2;
endpackage

// File: rtl/line_buf_sequencer.sv
// line_buf_sequencer: steps four external line buffers through a frame and flags complete 5x5 windows.
module line_buf_sequencer
  import blur_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sof,
  input  logic       pix_valid,
  output logic [3:0] buf_wr_en,
  output logic [3:0] buf_rd_en,
  output logic [1:0] row_rot,
  output logic       win_valid,
  output logic [9:0] win_col,
  output logic [9:0] win_row,
  output logic       busy,
  output logic       frame_done
);
  state_t state;
  logic [9:0] col, line, c, l;
  logic [1:0] wr_sel, s;
  logic acc, run_px, eol, last, win_hit;
  // sof restarts the frame on this very pixel, so c/l/s are the coordinates it is accepted at
  always_comb begin
    acc = pix_valid && (sof || state == FILL || state == RUN);
    c = sof ? '0 : col;
    l = sof ? '0 : line;
    s = sof ? '0 : wr_sel;
    eol = c == 10'(IMG_W - 1);
    last = eol && l == 10'(IMG_H - 1);
    run_px = acc && !sof && state == RUN;
    win_hit = run_px && c >= 10'(KSIZE - 1);
    buf_wr_en = acc ? 4'b0001 << s : 4'b0000;
    buf_rd_en = run_px ? 4'b1111 : 4'b0000;
  end
  assign row_rot = wr_sel;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      line <= '0;
      wr_sel <= '0;
      win_valid <= 1'b0;
      win_col <= '0;
      win_row <= '0;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= acc && last;
      win_valid <= win_hit;
      if (win_hit) begin
        win_col <= c - 10'(HALF);
        win_row <= l - 10'(HALF);
      end
      if (acc) begin
        col <= eol ? '0 : c + 10'd1;
        line <= eol ? l + 10'd1 : l;
        wr_sel <= eol ? s + 2'd1 : s;
        state <= last ? DONE : (eol && l == 10'(NBUF - 1)) ? RUN : sof ? FILL : state;
        busy <= !last;
      end else if (state == DONE) begin
        state <= IDLE;
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_line_buf_sequencer.sv
// tb_line_buf_sequencer: directed 8x6 frames covering reset, fill/run, windows, gaps, abort and frame end.
module tb_line_buf_sequencer;
  import blur_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sof = 1'b0;
  logic pix_valid = 1'b0;
  logic [3:0] buf_wr_en, buf_rd_en;
  logic [1:0] row_rot;
  logic win_valid, busy, frame_done;
  logic [9:0] win_col, win_row;
  int checks = 0;
  int failures = 0;
  int nwin = 0;
  logic [9:0] exp_wc = '0;
  logic [9:0] exp_wr = '0;
  logic [19:0] wq[$];
  logic [19:0] q0[$];

  line_buf_sequencer #(.IMG_W(8), .IMG_H(6)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid),
    .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en), .row_rot(row_rot),
    .win_valid(win_valid), .win_col(win_col), .win_row(win_row),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic px(input logic s, input logic v);
    @(negedge clk);
    sof = s;
    pix_valid = v;
    #1;
  endtask

  task automatic frame(input bit gaps);
    for (int y = 0; y < 6; y++)
      for (int x = 0; x < 8; x++) begin
        if (gaps)
          repeat ($urandom_range(0, 2)) begin
            px(1'b0, 1'b0);
            chk("gap_wr_en", buf_wr_en, 0);
            chk("gap_rd_en", buf_rd_en, 0);
            @(posedge clk); #1;
            chk("gap_win_valid", win_valid, 0);
            chk("gap_win_col", win_col, exp_wc);
            chk("gap_win_row", win_row, exp_wr);
          end
        px(x == 0 && y == 0, 1'b1);
        chk("wr_en", buf_wr_en, 1 << (y % 4));
        chk("rd_en", buf_rd_en, y >= 4 ? 4'hf : 4'h0);
        if (x != 0 || y != 0) chk("row_rot", row_rot, y % 4);
        @(posedge clk); #1;
        if (y >= 4 && x >= 4) begin
          exp_wc = 10'(x - 2);
          exp_wr = 10'(y - 2);
        end
        chk("win_valid", win_valid, y >= 4 && x >= 4);
        chk("win_col", win_col, exp_wc);
        chk("win_row", win_row, exp_wr);
        chk("frame_done", frame_done, x == 7 && y == 5);
        chk("busy", busy, !(x == 7 && y == 5));
        if (win_valid) begin
          nwin++;
          wq.push_back({win_row, win_col});
        end
      end
  endtask

  initial begin
    #1;
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_row_rot", row_rot, 0);
    #20 rst = 1'b0;
    // partial frame into line 2, then async reset mid-cycle
    for (int i = 0; i < 19; i++) px(i == 0, 1'b1);
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_row_rot", row_rot, 2);
    px(1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_state", dut.state, IDLE);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_row_rot", row_rot, 0);
    chk("mid_rst_win", {win_valid, win_col, win_row}, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      px(1'b0, 1'b1);
      chk("nosof_wr_en", buf_wr_en, 0);
      chk("nosof_rd_en", buf_rd_en, 0);
      @(posedge clk); #1;
      chk("nosof_state", dut.state, IDLE);
      chk("nosof_busy", busy, 0);
      chk("nosof_outs", {win_valid, frame_done, row_rot}, 0);
    end
    // gapless reference frame
    nwin = 0;
    wq.delete();
    frame(1'b0);
    chk("win_count", nwin, 8);
    chk("first_win", wq.size() > 0 ? wq[0] : 20'hfffff, {10'd2, 10'd2});
    q0 = wq;
    // pixels after frame end are ignored
    for (int i = 0; i < 3; i++) begin
      px(1'b0, 1'b1);
      chk("post_wr_en", buf_wr_en, 0);
      @(posedge clk); #1;
      chk("post_frame_done", frame_done, 0);
      chk("post_busy", busy, 0);
      chk("post_state", dut.state, IDLE);
    end
    // same frame with random gaps
    nwin = 0;
    wq.delete();
    frame(1'b1);
    chk("gap_win_count", nwin, 8);
    chk("gap_seq_len", wq.size(), q0.size());
    for (int i = 0; i < wq.size() && i < q0.size(); i++) chk("gap_seq", wq[i], q0[i]);
    // abort at (3,3): restart with sof and complete a fresh frame
    for (int i = 0; i < 27; i++) begin
      px(i == 0, 1'b1);
      @(posedge clk); #1;
      chk("abort_frame_done", frame_done, 0);
    end
    chk("abort_row_rot", row_rot, 3);
    nwin = 0;
    frame(1'b0);
    chk("abort_win_count", nwin, 8);
    px(1'b0, 1'b0);
    @(posedge clk); #1;
    chk("done_pulse_len", frame_done, 0);
    chk("done_state", dut.state, IDLE);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
